// File: rtl/b_format_decoder.sv
// B-form (bc/bca/bcl/bcla, primary opcode 16) decoder producing a registered branch-unit micro-op.
// Optional BO reserved-encoding rejection is enabled by defining BDEC_BO_RESERVED_CHECK_EN.
module b_format_decoder #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 5,
  parameter int opcodeSize              = 12,
  parameter int PrimOpcodeSize          = 6,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = 6,
  parameter int B                       = 2,
  parameter int BDecoderInstance        = 0
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               stall_i,
  input  logic [24:0]                        instFormat_i,
  input  logic [PrimOpcodeSize-1:0]          instructionOpcode_i,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  output logic                               enable_o,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic [instMinIdWidth-1:0]          numMicroOps_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic                               modifiesCR_o,
  output logic [27:0]                        instructionBody_o
);

  // Re-index the word so bit 0 is the MSB, matching the architecture's field numbering.
  logic [0:instructionWidth-1] ibmBits;

  genvar gi;
  generate
    for (gi = 0; gi < instructionWidth; gi++) begin : gBitReverse
      assign ibmBits[gi] = instruction_i[instructionWidth-1-gi];
    end
  endgenerate

  logic [regSize-1:0]       boField;
  logic [regSize-1:0]       biField;
  logic [immediateSize-1:0] bdField;
  logic                     aaBit;
  logic                     lkBit;
  logic                     boReserved;
  logic                     acceptPacket;

  assign boField = ibmBits[6:10];
  assign biField = ibmBits[11:15];
  assign bdField = ibmBits[16:29];
  assign aaBit   = ibmBits[30];
  assign lkBit   = ibmBits[31];

`ifdef BDEC_BO_RESERVED_CHECK_EN
  // "Branch always" (BO0 and BO2 set) requires the remaining BO bits to be zero.
  assign boReserved = boField[4] & boField[2] & (boField[3] | boField[1] | boField[0]);
`else
  assign boReserved = 1'b0;
`endif

  assign acceptPacket = enable_i
                      && (instFormat_i == 25'(B))
                      && (instructionOpcode_i == PrimOpcodeSize'(16))
                      && !boReserved;

  // The primary opcode bits of the word are deliberately not rechecked.
  logic unusedBits;
  assign unusedBits = ^{ibmBits[0:5], (BDecoderInstance != 0)};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      enable_o             <= 1'b0;
      opcode_o             <= '0;
      instructionAddress_o <= '0;
      functionalUnitType_o <= '0;
      instMajId_o          <= '0;
      instMinId_o          <= '0;
      numMicroOps_o        <= '0;
      is64Bit_o            <= 1'b0;
      instPid_o            <= '0;
      instTid_o            <= '0;
      modifiesCR_o         <= 1'b0;
      instructionBody_o    <= '0;
    end else if (!stall_i) begin
      enable_o <= acceptPacket;
      // Payload fields keep stale values when nothing is accepted; enable_o qualifies them.
      if (acceptPacket) begin
        opcode_o             <= {6'b010000, 4'b0000, aaBit, lkBit};
        instructionAddress_o <= instructionAddress_i;
        functionalUnitType_o <= funcUnitCodeSize'(BranchUnitID);
        instMajId_o          <= instructionMajId_i;
        instMinId_o          <= '0;
        numMicroOps_o        <= instMinIdWidth'(1);
        is64Bit_o            <= is64Bit_i;
        instPid_o            <= instructionPid_i;
        instTid_o            <= instructionTid_i;
        modifiesCR_o         <= 1'b0;
        instructionBody_o    <= {boField, biField, bdField, aaBit, lkBit, 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_b_format_decoder.sv
// Directed-vector self-checking bench for b_format_decoder.
module tb_b_format_decoder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        stall_i;
  logic [24:0] instFormat_i;
  logic [5:0]  instructionOpcode_i;
  logic [31:0] instruction_i;
  logic [63:0] instructionAddress_i;
  logic        is64Bit_i;
  logic [19:0] instructionPid_i;
  logic [15:0] instructionTid_i;
  logic [63:0] instructionMajId_i;
  logic        enable_o;
  logic [11:0] opcode_o;
  logic [63:0] instructionAddress_o;
  logic [2:0]  functionalUnitType_o;
  logic [63:0] instMajId_o;
  logic [4:0]  instMinId_o;
  logic [4:0]  numMicroOps_o;
  logic        is64Bit_o;
  logic [19:0] instPid_o;
  logic [15:0] instTid_o;
  logic        modifiesCR_o;
  logic [27:0] instructionBody_o;

  int testsRun = 0;
  int testsFailed = 0;
  int enableCount = 0;
  logic expectBoReject;

  b_format_decoder dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .stall_i(stall_i),
    .instFormat_i(instFormat_i), .instructionOpcode_i(instructionOpcode_i),
    .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
    .is64Bit_i(is64Bit_i), .instructionPid_i(instructionPid_i),
    .instructionTid_i(instructionTid_i), .instructionMajId_i(instructionMajId_i),
    .enable_o(enable_o), .opcode_o(opcode_o), .instructionAddress_o(instructionAddress_o),
    .functionalUnitType_o(functionalUnitType_o), .instMajId_o(instMajId_o),
    .instMinId_o(instMinId_o), .numMicroOps_o(numMicroOps_o), .is64Bit_o(is64Bit_o),
    .instPid_o(instPid_o), .instTid_o(instTid_o), .modifiesCR_o(modifiesCR_o),
    .instructionBody_o(instructionBody_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [31:0] mkInst(input logic [5:0] op, input logic [4:0] bo,
                                         input logic [4:0] bi, input logic [13:0] bd,
                                         input logic aa, input logic lk);
    return {op, bo, bi, bd, aa, lk};
  endfunction

  task automatic drivePacket(input logic [5:0] op, input logic [31:0] inst, input logic [63:0] addr);
    enable_i             = 1'b1;
    instFormat_i         = 25'd2;
    instructionOpcode_i  = op;
    instruction_i        = inst;
    instructionAddress_i = addr;
    instructionMajId_i   = addr;
  endtask

  initial begin
    // Reset with a valid packet on the inputs: reset must dominate.
    reset_i = 1'b1; stall_i = 1'b0; is64Bit_i = 1'b1;
    instructionPid_i = 20'hABCDE; instructionTid_i = 16'h1234;
    drivePacket(6'd16, 32'h41D10FF3, 64'd16);
    step();
    $display("[TB] reset cycle");
    checkValue("rst_enable", 64'(enable_o), 64'd0);
    checkValue("rst_opcode", 64'(opcode_o), 64'd0);
    checkValue("rst_address", instructionAddress_o, 64'd0);
    checkValue("rst_fu", 64'(functionalUnitType_o), 64'd0);
    checkValue("rst_majid", instMajId_o, 64'd0);
    checkValue("rst_minid", 64'(instMinId_o), 64'd0);
    checkValue("rst_numuops", 64'(numMicroOps_o), 64'd0);
    checkValue("rst_is64", 64'(is64Bit_o), 64'd0);
    checkValue("rst_pid", 64'(instPid_o), 64'd0);
    checkValue("rst_tid", 64'(instTid_o), 64'd0);
    checkValue("rst_modcr", 64'(modifiesCR_o), 64'd0);
    checkValue("rst_body", 64'(instructionBody_o), 64'd0);
    reset_i = 1'b0;

    // Opcode sweep: only 16 is accepted.
    for (int op = 0; op < 64; op++) begin
      drivePacket(6'(op), mkInst(6'(op), 5'b01110, 5'b10001, 14'b00001111111100, 1'b1, 1'b1), 64'd16);
      step();
      $display("[TB] sweep opcode %0d enable_o=%0d", op, enable_o);
      checkValue($sformatf("sweep_op%0d", op), 64'(enable_o), (op == 16) ? 64'd1 : 64'd0);
      if (enable_o) enableCount++;
    end
    checkValue("sweep_count", 64'(enableCount), 64'd1);

    // Full decode of 0x41D10FF3.
    drivePacket(6'd16, 32'h41D10FF3, 64'd16);
    step();
    $display("[TB] decode 0x41D10FF3 opcode_o=0x%0h body=0x%0h", opcode_o, instructionBody_o);
    checkValue("dec_enable", 64'(enable_o), 64'd1);
    checkValue("dec_opcode", 64'(opcode_o), 64'h403);
    checkValue("dec_fu", 64'(functionalUnitType_o), 64'd6);
    checkValue("dec_body", 64'(instructionBody_o), 64'(28'b0111010001000011111111001100));
    checkValue("dec_address", instructionAddress_o, 64'd16);
    checkValue("dec_majid", instMajId_o, 64'd16);
    checkValue("dec_numuops", 64'(numMicroOps_o), 64'd1);
    checkValue("dec_minid", 64'(instMinId_o), 64'd0);
    checkValue("dec_modcr", 64'(modifiesCR_o), 64'd0);
    checkValue("dec_is64", 64'(is64Bit_o), 64'd1);
    checkValue("dec_pid", 64'(instPid_o), 64'hABCDE);
    checkValue("dec_tid", 64'(instTid_o), 64'h1234);

    // Wrong format tag, then enable low.
    instFormat_i = 25'd4;
    step();
    $display("[TB] format 4 enable_o=%0d", enable_o);
    checkValue("fmt4_enable", 64'(enable_o), 64'd0);
    instFormat_i = 25'd2; enable_i = 1'b0;
    step();
    $display("[TB] enable_i=0 enable_o=%0d", enable_o);
    checkValue("noen_enable", 64'(enable_o), 64'd0);

    // Accept, then stall with a different packet on the inputs.
    drivePacket(6'd16, 32'h41D10FF3, 64'd16);
    step();
    checkValue("pre_stall_enable", 64'(enable_o), 64'd1);
    stall_i = 1'b1;
    drivePacket(6'd16, mkInst(6'd16, 5'b00100, 5'b00011, 14'h0005, 1'b0, 1'b1), 64'h100);
    is64Bit_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      $display("[TB] stalled cycle %0d address=0x%0h", i, instructionAddress_o);
      checkValue("stall_enable", 64'(enable_o), 64'd1);
      checkValue("stall_address", instructionAddress_o, 64'd16);
      checkValue("stall_opcode", 64'(opcode_o), 64'h403);
      checkValue("stall_body", 64'(instructionBody_o), 64'(28'b0111010001000011111111001100));
      checkValue("stall_is64", 64'(is64Bit_o), 64'd1);
    end
    stall_i = 1'b0;
    step();
    $display("[TB] stall released address=0x%0h", instructionAddress_o);
    checkValue("post_stall_enable", 64'(enable_o), 64'd1);
    checkValue("post_stall_address", instructionAddress_o, 64'h100);
    checkValue("post_stall_opcode", 64'(opcode_o), 64'h401);
    checkValue("post_stall_body", 64'(instructionBody_o), 64'(28'b0010000011000000000001010100));
    checkValue("post_stall_is64", 64'(is64Bit_o), 64'd0);
    enable_i = 1'b0;
    step();
    checkValue("pulse_end", 64'(enable_o), 64'd0);

    // BO "branch always" encodings.
`ifdef BDEC_BO_RESERVED_CHECK_EN
    expectBoReject = 1'b1;
`else
    expectBoReject = 1'b0;
`endif
    drivePacket(6'd16, mkInst(6'd16, 5'b10100, 5'b00000, 14'h0000, 1'b0, 1'b0), 64'h200);
    step();
    $display("[TB] BO=10100 enable_o=%0d", enable_o);
    checkValue("bo10100_enable", 64'(enable_o), 64'd1);
    checkValue("bo10100_opcode", 64'(opcode_o), 64'h400);
    drivePacket(6'd16, mkInst(6'd16, 5'b11100, 5'b00000, 14'h0000, 1'b0, 1'b0), 64'h204);
    step();
    $display("[TB] BO=11100 enable_o=%0d", enable_o);
    checkValue("bo11100_enable", 64'(enable_o), expectBoReject ? 64'd0 : 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
